// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath controls.
// Optional macro ILLEGAL_OP_TRAP_EN: unknown opcodes park the machine in TRAP instead of acting as NOPs.
module multicycle_control_unit #(
  parameter int                  OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [3:0]          state,
  output logic                PCWre,
  output logic                IRWre,
  output logic                InsMemRW,
  output logic [1:0]          ExtSel,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic [2:0]          ALUOp,
  output logic                RegWre,
  output logic [1:0]          RegDst,
  output logic                WrRegDSrc,
  output logic                DBDataSrc,
  output logic                mRD,
  output logic                mWR,
  output logic [1:0]          PCSrc,
  output logic                illegal_op
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_L   = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000,
    S_TRAP   = 4'b1001
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_J    = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 6'b111010;

  state_t r_state;

  logic w_isAdd, w_isSub, w_isAddi, w_isOr, w_isAnd, w_isOri, w_isSll, w_isSlt;
  logic w_isSw, w_isLw, w_isBeq, w_isJ, w_isJr, w_isJal, w_isHalt;
  logic w_isAlu, w_isLs, w_isJmp, w_isUnknown, w_inInstr;

  assign w_isAdd  = (opcode == OP_ADD);
  assign w_isSub  = (opcode == OP_SUB);
  assign w_isAddi = (opcode == OP_ADDI);
  assign w_isOr   = (opcode == OP_OR);
  assign w_isAnd  = (opcode == OP_AND);
  assign w_isOri  = (opcode == OP_ORI);
  assign w_isSll  = (opcode == OP_SLL);
  assign w_isSlt  = (opcode == OP_SLT);
  assign w_isSw   = (opcode == OP_SW);
  assign w_isLw   = (opcode == OP_LW);
  assign w_isBeq  = (opcode == OP_BEQ);
  assign w_isJ    = (opcode == OP_J);
  assign w_isJr   = (opcode == OP_JR);
  assign w_isJal  = (opcode == OP_JAL);
  assign w_isHalt = (opcode == HALT_OPCODE);

  assign w_isAlu     = w_isAdd | w_isSub | w_isAddi | w_isOr | w_isAnd | w_isOri | w_isSll | w_isSlt;
  assign w_isLs      = w_isLw | w_isSw;
  assign w_isJmp     = w_isJ | w_isJr | w_isJal;
  assign w_isUnknown = ~(w_isAlu | w_isLs | w_isJmp | w_isBeq | w_isHalt);
  assign w_inInstr   = (r_state inside {S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_L});

  // Reset overrides every transition, including the HALT/TRAP parking states.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF:     r_state <= S_ID;
        S_ID: begin
          if (w_isAlu)       r_state <= S_EXE_AL;
          else if (w_isBeq)  r_state <= S_EXE_BR;
          else if (w_isLs)   r_state <= S_EXE_LS;
          else if (w_isHalt) r_state <= S_HALT;
          else if (w_isJmp)  r_state <= S_IF;
`ifdef ILLEGAL_OP_TRAP_EN
          else               r_state <= S_TRAP;
`else
          else               r_state <= S_IF;
`endif
        end
        S_EXE_AL: r_state <= S_WB_AL;
        S_WB_AL:  r_state <= S_IF;
        S_EXE_BR: r_state <= S_IF;
        S_EXE_LS: r_state <= S_MEM;
        S_MEM:    r_state <= w_isLw ? S_WB_L : S_IF;
        S_WB_L:   r_state <= S_IF;
        S_HALT:   r_state <= S_HALT;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_IF;
      endcase
    end
  end

  assign state    = r_state;
  assign InsMemRW = 1'b1;

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = (r_state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

  // Opcode-driven selects stay valid for the whole instruction; strobes fire only in their state.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 2'd2;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegWre    = 1'b0;
    RegDst    = 2'b10;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;

    if (w_inInstr) begin
      if (w_isSll)      ExtSel = 2'd0;
      else if (w_isOri) ExtSel = 2'd1;
      ALUSrcA = w_isSll;
      ALUSrcB = w_isAddi | w_isOri | w_isLs;
      if (w_isSub | w_isBeq)     ALUOp = 3'b001;
      else if (w_isOr | w_isOri) ALUOp = 3'b100;
      else if (w_isAnd)          ALUOp = 3'b101;
      else if (w_isSll)          ALUOp = 3'b011;
      else if (w_isSlt)          ALUOp = 3'b010;
      if (w_isAddi | w_isOri | w_isLw) RegDst = 2'b01;
    end

    case (r_state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (w_isJal) begin
          RegWre    = 1'b1;
          RegDst    = 2'b00;
          WrRegDSrc = 1'b0;
        end
        if (w_isJr)               PCSrc = 2'b10;
        else if (w_isJ | w_isJal) PCSrc = 2'b11;
`ifdef ILLEGAL_OP_TRAP_EN
        PCWre = w_isJmp;
`else
        PCWre = w_isJmp | w_isUnknown;
`endif
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = zero ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        mRD       = w_isLw;
        mWR       = w_isSw;
        DBDataSrc = w_isLw;
        PCWre     = w_isSw;
      end
      S_WB_AL: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
      end
      S_WB_L: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        DBDataSrc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
